// File: rtl/fake_netlist_bist_driver.sv
// ---------------------------------------------------------------------------
// fake_netlist_bist_driver
//
// Stimulus/capture stage for a small combinational netlist under test.
// It drives a registered pattern onto the netlist inputs and holds it for a
// settle time. It then samples the single netlist output and folds it into a
// MISR signature and a ones count. Each netlist can then be fingerprinted
// in-system from the signature and the ones count.
//
// Ports
//   clk_i          rising-edge clock
//   rst_n_i        synchronous reset, active low
//   start_i        run request, only looked at in IDLE
//   abort_i        cancels a run in progress (also blocks a start in IDLE)
//   resp_in_i      netlist output
//   pat_out_o      registered pattern to netlist inputs (bit i -> input i)
//   busy_o         high while patterns are being applied/captured
//   done_o         one-cycle pulse when a run completes normally
//   signature_o    MISR signature, held after the run
//   ones_cnt_o     number of captured responses equal to 1
//   pat_idx_o      index of the pattern currently applied
//
// State table
//   state      | meaning
//   S_IDLE     | waiting for start, results from the last run held
//   S_APPLY    | pattern driven, hold counter running down to settle
//   S_CAPTURE  | resp_in sampled into MISR/ones count, advance pattern
//   S_DONE     | single-cycle completion pulse, then back to IDLE
// ---------------------------------------------------------------------------
module fake_netlist_bist_driver #(
    parameter int                 IN_W      = 5,
    parameter int                 MODE      = 0,
    parameter logic [IN_W-1:0]    LFSR_SEED = 5'h01,
    parameter int                 NUM_PAT   = 32,
    parameter int                 SETTLE    = 1,
    parameter int                 MISR_W    = 16,
    parameter logic [MISR_W-1:0]  MISR_POLY = 16'h1021
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              resp_in_i,
    output logic [IN_W-1:0]   pat_out_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [MISR_W-1:0] signature_o,
    output logic [IN_W:0]     ones_cnt_o,
    output logic [IN_W:0]     pat_idx_o
);

    localparam int              IDX_W     = IN_W + 1;
    localparam logic [2:0]      SETTLE_L  = 3'(SETTLE);
    localparam logic [IN_W:0]   LAST_IDX  = IDX_W'(NUM_PAT - 1);
    localparam logic [IN_W-1:0] PAT_FIRST = (MODE == 1) ? LFSR_SEED : '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          hold_q, hold_d;
    logic [IN_W-1:0]     pat_q, pat_d;
    logic [MISR_W-1:0]   sig_q, sig_d;
    logic [IN_W:0]       ones_q, ones_d;
    logic [IN_W:0]       idx_q, idx_d;

    logic [IN_W-1:0]     lfsr_next;
    logic [IN_W-1:0]     pat_next;
    logic [MISR_W-1:0]   misr_next;

    // Fibonacci LFSR x^5+x^3+1: shift left, feed back tap 4 xor tap 2.
    assign lfsr_next = {pat_q[IN_W-2:0], pat_q[IN_W-1] ^ pat_q[IN_W-3]};
    assign pat_next  = (MODE == 1) ? lfsr_next : pat_q + IN_W'(1);

    assign misr_next = {sig_q[MISR_W-2:0], 1'b0}
                     ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
                     ^ {{(MISR_W-1){1'b0}}, resp_in_i};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            pat_q   <= '0;
            sig_q   <= '0;
            ones_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pat_q   <= pat_d;
            sig_q   <= sig_d;
            ones_q  <= ones_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pat_d   = pat_q;
        sig_d   = sig_q;
        ones_d  = ones_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                // abort beats a simultaneous start
                if (start_i && !abort_i) begin
                    state_d = S_APPLY;
                    hold_d  = SETTLE_L;
                    pat_d   = PAT_FIRST;
                    sig_d   = '0;
                    ones_d  = '0;
                    idx_d   = '0;
                end
            end

            S_APPLY: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (hold_q == 3'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    hold_d = hold_q - 3'd1;
                end
            end

            S_CAPTURE: begin
                // An abort here drops the capture so partial results stay
                // consistent with pat_idx.
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    sig_d  = misr_next;
                    ones_d = ones_q + IDX_W'(resp_in_i);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_APPLY;
                        idx_d   = idx_q + IDX_W'(1);
                        pat_d   = pat_next;
                        hold_d  = SETTLE_L;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pat_out_o   = pat_q;
    assign busy_o      = (state_q == S_APPLY) || (state_q == S_CAPTURE);
    assign done_o      = (state_q == S_DONE);
    assign signature_o = sig_q;
    assign ones_cnt_o  = ones_q;
    assign pat_idx_o   = idx_q;

endmodule

// File: tb/tb_fake_netlist_bist_driver.sv
// ---------------------------------------------------------------------------
// Testbench for fake_netlist_bist_driver.
// Three instances cover the default exhaustive configuration, the LFSR
// configuration (31 patterns, no settle) and a single-pattern run with a
// long settle. Each netlist is modelled as a 32-entry truth table indexed by
// pat_out. Expected run results come from a pattern-list/MISR model and are
// queued when a run is started; a monitor checks every run as it ends.
// ---------------------------------------------------------------------------
module tb_fake_netlist_bist_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0]  abort_v;
    logic [31:0] tt [3];

    logic [4:0]  pat0, pat1, pat2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] sig0, sig1, sig2;
    logic [5:0]  ones0, ones1, ones2;
    logic [5:0]  idx0, idx1, idx2;
    logic        resp0, resp1, resp2;

    assign resp0 = tt[0][pat0];
    assign resp1 = tt[1][pat1];
    assign resp2 = tt[2][pat2];

    fake_netlist_bist_driver dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_v[0]), .abort_i(abort_v[0]),
        .resp_in_i(resp0), .pat_out_o(pat0), .busy_o(busy0), .done_o(done0),
        .signature_o(sig0), .ones_cnt_o(ones0), .pat_idx_o(idx0)
    );

    fake_netlist_bist_driver #(.MODE(1), .LFSR_SEED(5'h01), .NUM_PAT(31), .SETTLE(0)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_v[1]), .abort_i(abort_v[1]),
        .resp_in_i(resp1), .pat_out_o(pat1), .busy_o(busy1), .done_o(done1),
        .signature_o(sig1), .ones_cnt_o(ones1), .pat_idx_o(idx1)
    );

    fake_netlist_bist_driver #(.NUM_PAT(1), .SETTLE(3)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_v[2]), .abort_i(abort_v[2]),
        .resp_in_i(resp2), .pat_out_o(pat2), .busy_o(busy2), .done_o(done2),
        .signature_o(sig2), .ones_cnt_o(ones2), .pat_idx_o(idx2)
    );

    logic [4:0]  pat_a  [3];
    logic        busy_a [3];
    logic        done_a [3];
    logic [15:0] sig_a  [3];
    logic [5:0]  ones_a [3];
    logic [5:0]  idx_a  [3];

    always_comb begin
        pat_a[0]  = pat0;  pat_a[1]  = pat1;  pat_a[2]  = pat2;
        busy_a[0] = busy0; busy_a[1] = busy1; busy_a[2] = busy2;
        done_a[0] = done0; done_a[1] = done1; done_a[2] = done2;
        sig_a[0]  = sig0;  sig_a[1]  = sig1;  sig_a[2]  = sig2;
        ones_a[0] = ones0; ones_a[1] = ones1; ones_a[2] = ones2;
        idx_a[0]  = idx0;  idx_a[1]  = idx1;  idx_a[2]  = idx2;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        bit          aborted;
        logic [15:0] sig;
        logic [5:0]  ones;
        logic [5:0]  idx;
        int          cycles;
    } exp_t;

    exp_t exp_q [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, got no event, expected one at %0t", name, $time);
    endtask

    // Per-instance configuration.
    function automatic int mode_of(int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int npat_of(int i);
        case (i)
            0:       return 32;
            1:       return 31;
            default: return 1;
        endcase
    endfunction

    function automatic int settle_of(int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    // k-th pattern of a run: plain count, or k steps of the x^5+x^3+1 LFSR.
    function automatic logic [4:0] model_pat(int i, int k);
        logic [4:0] x;
        if (mode_of(i) == 0) return 5'(k % 32);
        x = 5'h01;
        for (int n = 0; n < k; n++) x = {x[3:0], x[4] ^ x[2]};
        return x;
    endfunction

    // Polynomial-division view of the MISR: multiply by x mod P, add bit.
    function automatic logic [15:0] misr_fold(logic [15:0] s, logic b);
        int v;
        v = int'(s) * 2;
        if (v > 65535) v = (v - 65536) ^ 32'h1021;
        v = v ^ int'(b);
        return v[15:0];
    endfunction

    task automatic push_exp(int i, logic [31:0] t, int abort_at);
        exp_t e;
        int ncap;
        int o;
        logic [15:0] s;
        logic b;
        ncap = (abort_at >= 0) ? abort_at : npat_of(i);
        s = '0;
        o = 0;
        for (int k = 0; k < ncap; k++) begin
            b = t[model_pat(i, k)];
            s = misr_fold(s, b);
            o += int'(b);
        end
        e.inst    = i;
        e.aborted = (abort_at >= 0);
        e.sig     = s;
        e.ones    = 6'(o);
        e.idx     = e.aborted ? 6'(abort_at) : 6'(npat_of(i) - 1);
        e.cycles  = e.aborted ? abort_at * (settle_of(i) + 2) + 1
                              : npat_of(i) * (settle_of(i) + 2);
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic        prev_busy [3];
    int          busy_cnt  [3];
    int          hold_cnt  [3];
    int          pat_k     [3];
    logic [4:0]  last_pat  [3];
    logic [31:0] seen_m    [3];
    exp_t        me;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                prev_busy[i] = 1'b0;
            end else begin
                if (done_a[i]) check("done_follows_busy", prev_busy[i], 1);
                if (busy_a[i]) begin
                    if (!prev_busy[i]) begin
                        busy_cnt[i] = 1;
                        hold_cnt[i] = 1;
                        pat_k[i]    = 0;
                        last_pat[i] = pat_a[i];
                        seen_m[i]   = '0;
                        seen_m[i][pat_a[i]] = 1'b1;
                        check("first_pattern", pat_a[i], model_pat(i, 0));
                        check("start_idx", idx_a[i], 0);
                        check("start_sig_cleared", sig_a[i], 0);
                        check("start_ones_cleared", ones_a[i], 0);
                    end else begin
                        busy_cnt[i]++;
                        if (pat_a[i] != last_pat[i]) begin
                            check("hold_len", hold_cnt[i], settle_of(i) + 2);
                            pat_k[i]++;
                            check("pattern", pat_a[i], model_pat(i, pat_k[i]));
                            check("pat_idx", idx_a[i], pat_k[i]);
                            hold_cnt[i] = 1;
                            last_pat[i] = pat_a[i];
                            seen_m[i][pat_a[i]] = 1'b1;
                        end else begin
                            hold_cnt[i]++;
                        end
                    end
                end else if (prev_busy[i]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_run_end: inst %0d got a run end, expected none", i);
                    end else begin
                        me = exp_q.pop_front();
                        check("run_inst", i, me.inst);
                        check("done_pulse", done_a[i], !me.aborted);
                        check("signature", sig_a[i], me.sig);
                        check("ones_cnt", ones_a[i], me.ones);
                        check("final_idx", idx_a[i], me.idx);
                        check("busy_cycles", busy_cnt[i], me.cycles);
                        if (i == 1 && !me.aborted)
                            check("lfsr_coverage", seen_m[i], 32'hFFFF_FFFE);
                    end
                end
                prev_busy[i] = busy_a[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        for (int i = 0; i < 3; i++) begin
            check("rst_pat", pat_a[i], 0);
            check("rst_busy", busy_a[i], 0);
            check("rst_done", done_a[i], 0);
            check("rst_sig", sig_a[i], 0);
            check("rst_ones", ones_a[i], 0);
            check("rst_idx", idx_a[i], 0);
        end
    endtask

    task automatic run(int i, logic [31:0] t, int abort_at, bit mid_start, bit done_start);
        bit hit;
        tt[i] = t;
        push_exp(i, t, abort_at);
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
        if (abort_at >= 0) begin
            hit = 1'b0;
            for (int n = 0; n < 2000 && !hit; n++) begin
                if (busy_a[i] && idx_a[i] == 6'(abort_at)) hit = 1'b1;
                else tick();
            end
            if (!hit) begin
                timeout_fail("abort_point");
            end else begin
                abort_v[i] = 1'b1;
                tick();
                abort_v[i] = 1'b0;
                check("abort_busy_low", busy_a[i], 0);
                check("abort_no_done", done_a[i], 0);
                check("abort_idx_kept", idx_a[i], abort_at);
            end
        end else begin
            if (mid_start) begin
                repeat (5) tick();
                start_v[i] = 1'b1;
                tick();
                start_v[i] = 1'b0;
            end
            for (int n = 0; n < 3000 && busy_a[i]; n++) tick();
            if (busy_a[i]) begin
                timeout_fail("run_end");
            end else if (done_start) begin
                start_v[i] = 1'b1;
                tick();
                start_v[i] = 1'b0;
                check("start_in_done_ignored", busy_a[i], 0);
            end
        end
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        abort_v = '0;
        for (int i = 0; i < 3; i++) tt[i] = '0;
        repeat (3) tick();
        check_reset_vals();
        rst_n = 1'b1;
        tick();

        run(0, 32'h0000_0000, -1, 1'b0, 1'b0);
        run(0, 32'hFFFF_FFFF, -1, 1'b1, 1'b1);
        run(0, 32'hAAAA_AAAA, -1, 1'b0, 1'b0);
        run(1, $urandom, -1, 1'b0, 1'b0);
        run(1, $urandom, -1, 1'b0, 1'b1);

        // start and abort together in IDLE: nothing starts
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        check("start_abort_idle", busy_a[0], 0);
        tick();
        check("start_abort_idle2", busy_a[0], 0);

        run(0, $urandom, 10, 1'b0, 1'b0);
        run(0, $urandom, -1, 1'b0, 1'b0);
        run(2, $urandom, -1, 1'b0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            run(int'($urandom_range(0, 2)), $urandom, -1, 1'b0, 1'b0);
        end

        // reset in the middle of a run that also sees a stray start
        tt[0] = $urandom;
        push_exp(0, tt[0], -1);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (10) tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        tick();
        check_reset_vals();
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", busy_a[0], 0);
        tick();
        check("post_reset_idle2", busy_a[0], 0);

        run(0, $urandom, -1, 1'b0, 1'b0);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
